// File: rtl/buffer_read_packer.sv
// Reads words from the circular-buffer read port one at a time (IDLE/REQ/RELEASE/SETTLE)
// and packs PACK of them into one wide beat presented on a valid/ready output.
module buffer_read_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    localparam int CW        = $clog2(PACK + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       buf_empty,
    input  logic                       buf_valid,
    input  logic [DATA_WIDTH-1:0]      buf_data,
    output logic                       read_enable,
    output logic [DATA_WIDTH*PACK-1:0] out_data,
    output logic [CW-1:0]              out_count,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic                         read_enable_q, read_enable_d;
    logic [DATA_WIDTH-1:0]        lane_q [PACK];
    logic [DATA_WIDTH-1:0]        lane_d [PACK];
    logic [CW-1:0]                count_q, count_d;
    logic                         flush_q, flush_d;
    logic                         out_valid_q, out_valid_d;
    logic [DATA_WIDTH*PACK-1:0]   out_data_q, out_data_d;
    logic [CW-1:0]                out_count_q, out_count_d;

    logic full;
    logic flush_beat;
    logic beat_ready;
    logic out_free;

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        count_d     = count_q;
        flush_d     = flush_q | flush;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        full       = (count_q == CW'(PACK));
        flush_beat = (state_q == IDLE) && flush_q && (count_q != '0);
        beat_ready = full || flush_beat;
        out_free   = !out_valid_q || out_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // A flush with nothing packed is simply dropped.
                if (flush_q && (count_q == '0)) begin
                    flush_d = flush;
                end else if (en && !buf_empty && !beat_ready && !flush_q) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (buf_valid) begin
                    for (int k = 0; k < PACK; k++) begin
                        if (count_q == CW'(k)) begin
                            lane_d[k] = buf_data;
                        end
                    end
                    count_d = count_q + CW'(1);
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = SETTLE;   // controller still shows valid here
            SETTLE:  state_d = IDLE;     // pointer update, empty flag not yet trusted
            default: state_d = IDLE;
        endcase

        // Capture and transfer never coincide: REQ is only entered with room in the lanes.
        if (beat_ready && out_free) begin
            for (int k = 0; k < PACK; k++) begin
                out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = (CW'(k) < count_q) ? lane_q[k] : '0;
            end
            out_count_d = count_q;
            out_valid_d = 1'b1;
            count_d     = '0;
            flush_d     = 1'b0;
        end

        read_enable_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            read_enable_q <= 1'b0;
            for (int k = 0; k < PACK; k++) begin
                lane_q[k] <= '0;
            end
            count_q       <= '0;
            flush_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            read_enable_q <= read_enable_d;
            lane_q        <= lane_d;
            count_q       <= count_d;
            flush_q       <= flush_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_count_q   <= out_count_d;
        end
    end

    assign read_enable = read_enable_q;
    assign out_data    = out_data_q;
    assign out_count   = out_count_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_buffer_read_packer.sv
// Bench for buffer_read_packer: a small buffer-controller model feeds words, a scoreboard
// holds expected beats and a monitor pops/compares every accepted beat.
module tb_buffer_read_packer;

    localparam int DW = 8;
    localparam int PK = 4;
    localparam int CW = $clog2(PK + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             flush;
    logic             buf_empty;
    logic             buf_valid;
    logic [DW-1:0]    buf_data;
    logic             read_enable;
    logic [DW*PK-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    buffer_read_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .buf_empty  (buf_empty),
        .buf_valid  (buf_valid),
        .buf_data   (buf_data),
        .read_enable(read_enable),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // buffer contents: written by stimulus, read pointer owned by the controller model
    logic [DW-1:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic wr_req = 1'b0;
    logic manual = 1'b0;
    logic man_valid = 1'b0;
    logic [DW-1:0] man_data = '0;

    // scoreboard
    logic [DW*PK-1:0] exp_data [32];
    int               exp_cnt  [32];
    int exp_wr = 0;
    int exp_rd = 0;

    // read_enable pulse and handshake logs
    int rise [64];
    int width [64];
    int nr = 0;
    int hs [64];
    int nhs = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic expect_beat(input logic [DW*PK-1:0] d, input int c);
        exp_data[exp_wr] = d;
        exp_cnt[exp_wr]  = c;
        exp_wr++;
    endtask

    task automatic wait_sb(input int bound);
        int n = 0;
        while (exp_rd != exp_wr && n < bound) begin
            tick(1);
            n++;
        end
        chk("sb_drain_pending", 64'(exp_wr - exp_rd), 64'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // buffer controller model: sees read_enable, after one cycle shows valid for two
    // cycles (three cycles later when a write is being serviced), then updates pointer
    initial begin : ctrl
        typedef enum int {C_IDLE, C_WAIT, C_V1, C_V2, C_PTR} cst_t;
        cst_t cst = C_IDLE;
        int wcnt = 0;
        buf_valid = 1'b0;
        buf_data  = '0;
        buf_empty = 1'b1;
        forever begin
            @(negedge clk);
            if (manual) begin
                buf_valid = man_valid;
                buf_data  = man_data;
                rd_ptr    = wr_ptr;
                buf_empty = 1'b1;
                cst       = C_IDLE;
            end else begin
                case (cst)
                    C_IDLE: begin
                        buf_valid = 1'b0;
                        if (read_enable) begin
                            if (wr_req) begin
                                wcnt = 3;
                                cst  = C_WAIT;
                            end else begin
                                cst = C_V1;
                            end
                        end
                    end
                    C_WAIT: begin
                        wcnt--;
                        if (wcnt == 0) cst = C_V1;
                    end
                    C_V1: begin
                        buf_valid = 1'b1;
                        buf_data  = mem[rd_ptr];
                        cst       = C_V2;
                    end
                    C_V2: begin
                        buf_valid = 1'b1;
                        rd_ptr++;
                        cst = C_PTR;
                    end
                    default: begin
                        buf_valid = 1'b0;
                        cst       = C_IDLE;
                    end
                endcase
                buf_empty = (rd_ptr == wr_ptr);
            end
        end
    end

    // monitor: compares accepted beats, hold stability, logs read_enable pulses
    initial begin : mon
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [DW*PK-1:0] pd = '0;
        logic [CW-1:0] pc = '0;
        logic re_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (pv && !pr) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_data", 64'(out_data), 64'(pd));
                    chk("hold_count", 64'(out_count), 64'(pc));
                end
                if (out_valid && out_ready) begin
                    if (exp_rd == exp_wr) begin
                        chk("unexpected_beat_count", 64'(exp_wr - exp_rd), 64'd1);
                    end else begin
                        chk("beat_data", 64'(out_data), 64'(exp_data[exp_rd]));
                        chk("beat_count", 64'(out_count), 64'(exp_cnt[exp_rd]));
                        exp_rd++;
                    end
                    hs[nhs] = cyc;
                    nhs++;
                end
                pv = out_valid;
                pr = out_ready;
                pd = out_data;
                pc = out_count;
            end else begin
                pv = 1'b0;
                pr = 1'b0;
            end
            if (read_enable) begin
                if (!re_prev) begin
                    rise[nr]  = cyc;
                    width[nr] = 1;
                    nr++;
                end else begin
                    width[nr-1]++;
                end
            end
            re_prev = read_enable;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int r0;
        int h0;
        int n;
        rst = 1'b0; en = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_read_enable", 64'(read_enable), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        tick(2);
        rst = 1'b1;

        // four words into one beat, read pulses 2 wide and 5 apart
        put(8'h11); put(8'h22); put(8'h33); put(8'h44);
        expect_beat(32'h44332211, 4);
        r0 = nr;
        out_ready = 1'b1;
        tick(2);
        en = 1'b1;
        wait_sb(100);
        tick(5);
        chk("t1_pulses", 64'(nr - r0), 64'd4);
        for (int i = 0; i < 4; i++) chk("t1_width", 64'(width[r0+i]), 64'd2);
        for (int i = 1; i < 4; i++) chk("t1_period", 64'(rise[r0+i] - rise[r0+i-1]), 64'd5);
        chk("t1_busy", 64'(busy), 64'd0);

        // backpressure: second beat packs internally, reads stop, back-to-back release
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) put(8'(i));
        expect_beat(32'h04030201, 4);
        expect_beat(32'h08070605, 4);
        r0 = nr;
        n = 0;
        while (rd_ptr != wr_ptr && n < 150) begin tick(1); n++; end
        tick(10);
        chk("t2_pulses", 64'(nr - r0), 64'd8);
        for (int i = 0; i < 10; i++) begin
            chk("t2_re_idle", 64'(read_enable), 64'd0);
            tick(1);
        end
        chk("t2_out_valid", 64'(out_valid), 64'd1);
        chk("t2_out_data", 64'(out_data), 64'h04030201);
        chk("t2_busy", 64'(busy), 64'd1);
        chk("t2_internal_count", 64'(dut.count_q), 64'd4);
        h0 = nhs;
        out_ready = 1'b1;
        wait_sb(20);
        chk("t2_back_to_back", 64'(hs[h0+1] - hs[h0]), 64'd1);

        // flush during SETTLE of the second word
        put(8'hAA); put(8'hBB);
        r0 = nr;
        n = 0;
        while (!((nr - r0) >= 2 && !read_enable) && n < 100) begin tick(1); n++; end
        chk("t3_reached_release", 64'(n < 100), 64'd1);
        tick(1);
        flush = 1'b1;
        expect_beat(32'h0000BBAA, 2);
        tick(1);
        flush = 1'b0;
        wait_sb(20);
        tick(2);
        chk("t3_flag_clear", 64'(dut.flush_q), 64'd0);
        chk("t3_count_zero", 64'(dut.count_q), 64'd0);
        chk("t3_busy", 64'(busy), 64'd0);

        // write contention on the first read: REQ 3 cycles longer, single capture
        en = 1'b0;
        put(8'h51); put(8'h52); put(8'h53); put(8'h54);
        expect_beat(32'h54535251, 4);
        wr_req = 1'b1;
        r0 = nr;
        tick(1);
        en = 1'b1;
        n = 0;
        while (!read_enable && n < 20) begin tick(1); n++; end
        @(negedge clk);
        #1;
        wr_req = 1'b0;
        wait_sb(200);
        tick(3);
        chk("t4_pulses", 64'(nr - r0), 64'd4);
        chk("t4_long_req", 64'(width[r0]), 64'd5);
        for (int i = 1; i < 4; i++) chk("t4_width", 64'(width[r0+i]), 64'd2);

        // empty buffer: never request, stay idle; REQ on the cycle after empty falls
        for (int i = 0; i < 50; i++) begin
            tick(1);
            chk("t5_re_low", 64'(read_enable), 64'd0);
            chk("t5_busy_low", 64'(busy), 64'd0);
        end
        put(8'h77);
        tick(1);
        chk("t5_req_next", 64'(read_enable), 64'd1);

        // reset asserted during REQ, released with buf_valid held high and en low
        manual = 1'b1;
        man_valid = 1'b1;
        man_data = 8'hEE;
        rst = 1'b0;
        #1;
        chk("t6_rst_read_enable", 64'(read_enable), 64'd0);
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_out_data", 64'(out_data), 64'd0);
        chk("t6_rst_out_count", 64'(out_count), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        en = 1'b0;
        tick(2);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t6_no_capture", 64'(dut.count_q), 64'd0);
            chk("t6_re_low", 64'(read_enable), 64'd0);
        end
        chk("t6_busy", 64'(busy), 64'd0);
        man_valid = 1'b0;
        tick(2);
        manual = 1'b0;
        tick(3);
        chk("final_sb_empty", 64'(exp_wr - exp_rd), 64'd0);
        chk("final_out_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_read_packer.md
# buffer_read_packer

Consumer-side engine for the circular-buffer read port. It drives `read_enable` and captures `buf_data` on `buf_valid`, following the buffer controller's read sequence (idle → read → pointer update). It packs `PACK` consecutive words into one wide beat and presents that beat downstream on a valid/ready handshake. It sits between the buffer and the wide-datapath consumer.

## Interface
- `DATA_WIDTH`, 8, width of one buffer word
- `PACK`, 4, words per output beat (≥2)
- `CW`, `$clog2(PACK+1)`, width of `out_count` (derived, localparam)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  one clock; reset is asynchronous and active-low (`rst`=0 resets)
- `en`  in  1  permit new reads; sampled only in IDLE
- `flush`  in  1  pulse: emit a partially filled beat
- `buf_empty`  in  1  buffer empty flag
- `buf_valid`  in  1  buffer read-data valid (controller START_READ)
- `buf_data`  in  DATA_WIDTH  buffer read data
- `read_enable`  out  1  read request to buffer controller
- `out_data`  out  DATA_WIDTH*PACK  packed beat; word k in bits `[k*DATA_WIDTH +: DATA_WIDTH]`
- `out_count`  out  CW  number of valid words in beat (1..PACK)
- `out_valid`  out  1  beat valid
- `out_ready`  in  1  downstream accept
- `busy`  out  1  FSM not in IDLE, or lane count ≠ 0

## Operation
- FSM states: IDLE, REQ, RELEASE, SETTLE. `read_enable` = 1 only in REQ; it is a registered Moore output.
- IDLE → REQ when `en`=1, `buf_empty`=0, no complete beat is waiting, and no flush is pending. Otherwise the FSM stays in IDLE.
- REQ: hold `read_enable`. When `buf_valid`=1, capture `buf_data` into lane `count`, increment `count`, and go to RELEASE. With no `buf_valid`, remain in REQ indefinitely; a pending buffer write delays the read.
- RELEASE: `read_enable`=0. Ignore `buf_valid`, because the controller still shows valid for one cycle. Then go to SETTLE.
- SETTLE: wait one cycle for the controller pointer update, then go to IDLE. `buf_empty` is only trusted again in IDLE.
- `en` or `flush` changing during REQ/RELEASE/SETTLE never aborts the in-flight read.
- A beat is complete when `count`=PACK, or when a flush is pending in IDLE with `count`>0.
- Transfer of a complete beat to the output register happens in any cycle where the output register is empty (`out_valid`=0) or is being accepted (`out_valid`&`out_ready`).
  - On transfer: lanes are copied, unused lanes are zero, `out_count`=`count`, `count` is cleared, and the flush flag is cleared.
- `flush` sets a sticky flag on any cycle. In IDLE, if the flag is set and `count`=0, the flag clears with no beat emitted.
- Output handshake: once `out_valid`=1, `out_data` and `out_count` stay stable until an edge with `out_ready`=1. The output goes back-to-back if the next beat is complete in the same cycle.

## Timing
- Reset values: `read_enable`, `out_valid`, `out_data`, `out_count`, `busy`, `count`, flush flag and state (IDLE) are all 0. Reset applies immediately on assertion.
- Best case per word, no write contention:
  - cycle 0: IDLE decides.
  - cycles 1–2: REQ; controller valid in cycle 2, captured at the end of cycle 2.
  - cycle 3: RELEASE.
  - cycle 4: SETTLE.
  - cycle 5: IDLE.
  - Result: a 5-cycle period, with `read_enable` high for exactly 2 cycles.
- Capture-to-output: the last word captured at edge e gives `out_valid`=1 after edge e+1, when the output register is free.
- Write contention (controller services the write first): REQ lengthens by 3 cycles; there is exactly one capture.
- Reset mid-read: on release, the FSM starts from IDLE and discards any controller valid not requested from IDLE.

## Test plan
- DW=8, PACK=4. Buffer holds 0x11, 0x22, 0x33, 0x44; `en`=1, `out_ready`=1.
  - Required: `out_data`=0x44332211, `out_count`=4.
  - Four `read_enable` pulses, each 2 cycles wide, starting 5 cycles apart.
- `out_ready`=0 with 8 words 0x01..0x08 available.
  - Required: beat 0x04030201 is held stable, and the second beat packs internally.
  - `read_enable` stays 0 after the 8th word.
  - When `out_ready` rises, the bench sees 0x04030201 and then 0x08070605 on consecutive cycles.
- Words 0xAA, 0xBB, then a 1-cycle `flush` pulse during SETTLE.
  - Required: `out_data`=0x0000BBAA, `out_count`=2, flag cleared, `count`=0.
- Buffer write request in the same cycle as `read_enable` rises.
  - Required: 3-cycle-longer REQ, exactly one capture of the correct word, and the second valid cycle in RELEASE is ignored.
- `en`=1, `buf_empty`=1 for 50 cycles.
  - Required: `read_enable`=0 and `busy`=0 throughout. After empty falls, REQ is entered on the next cycle.
- `rst` driven low during REQ.
  - Required: all outputs 0 immediately. After release with `buf_valid` still 1 and `en`=0, no capture occurs and `count` stays 0.
